alu_issue_stage: RTL and testbench
==================================

# alu_issue_stage

Operand-issue and result-capture stage around the 32-bit combinational `alu`. It accepts one operation at a time over a valid/ready handshake. It holds the operands and the operation code stable on the ALU inputs for a programmable settle window, long enough for the gate-delay ripple chain to resolve. It then registers the ALU result, the overflow bit and a derived zero flag, and presents them to the consumer over a second valid/ready handshake. The block sits between the instruction/operand source and the `alu`, and between the `alu` and the writeback consumer.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 4: number of clock cycles the operands are held on the ALU before the result is sampled. Legal range 1..255.

Ports:
- `clk`  input  1  sole clock; all state updates on the rising edge.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `in_valid`  input  1  upstream has an operation.
- `in_ready`  output  1  block can accept an operation this cycle.
- `in_op`  input  3  ALU operation code, passed through opaquely.
- `in_a`  input  32  operand A.
- `in_b`  input  32  operand B.
- `alu_op`  output  3  registered operation driven to `alu.operation`.
- `alu_a`  output  32  registered operand A driven to `alu.a`.
- `alu_b`  output  32  registered operand B driven to `alu.b`.
- `alu_result`  input  32  from `alu.out`.
- `alu_overflow`  input  1  from `alu.overflow`.
- `out_valid`  output  1  captured result is available.
- `out_ready`  input  1  consumer takes the result this cycle.
- `out_result`  output  32  captured result.
- `out_overflow`  output  1  captured overflow.
- `out_zero`  output  1  1 when the captured result equals 32'h0.

## Operation
- State machine: IDLE, SETTLE, HOLD. Settle counter `cnt` is 8 bits.
- `in_ready` = rst_n AND (state==IDLE OR (state==HOLD AND out_ready)).
- Accept = in_valid AND in_ready, sampled at the clock edge.
- Transitions:
  - IDLE + accept: latch in_op/in_a/in_b into alu_op/alu_a/alu_b; cnt←SETTLE_CYCLES-1; go to SETTLE.
  - SETTLE, cnt≠0: cnt←cnt-1. Operand registers do not change.
  - SETTLE, cnt==0: capture out_result←alu_result, out_overflow←alu_overflow, out_zero←(alu_result==0); set out_valid←1; go to HOLD.
  - HOLD, out_ready=0: hold all outputs.
  - HOLD, out_ready=1, no accept: out_valid←0; go to IDLE. Operand registers keep their last value.
  - HOLD, out_ready=1, accept (same edge): complete the output handshake and latch new operands; cnt←SETTLE_CYCLES-1; go to SETTLE. out_valid←0.
- In IDLE, in_valid=0: nothing changes.
- Output registers change only on capture. Their values persist after the handshake until the next capture.
- No arithmetic is performed in this block beyond the 32-bit zero compare. Opcode semantics belong to `alu`.

## Timing
- Reset (rst_n low, asynchronous): state=IDLE, cnt=0. alu_op/alu_a/alu_b=0. out_result=0, out_overflow=0, out_zero=0, out_valid=0. in_ready=0 while rst_n is low and 1 from the first cycle after release.
- Latency: accept at edge k → capture and out_valid=1 at edge k+SETTLE_CYCLES.
- The ALU inputs are stable from edge k through at least edge k+SETTLE_CYCLES.
- Throughput: one operation per SETTLE_CYCLES+1 cycles when out_ready is held high.
- SETTLE_CYCLES=1: capture occurs on the edge after accept.
- Backpressure: out_valid stays high and all out_* stay stable until an edge with out_ready=1. in_ready stays 0 throughout SETTLE.
- Reset asserted mid-SETTLE or mid-HOLD: the operation is discarded and nothing is emitted after release.
- in_op/in_a/in_b are ignored on edges without an accept.

## Test plan
- Reset: hold rst_n=0 with random inputs. All outputs are 0 and in_ready=0. Release: in_ready=1 and out_valid=0.
- Single op, SETTLE_CYCLES=4, ALU stub = a+b with 3-cycle propagation: accept a=5, b=7 at edge k. alu_a/alu_b hold 5/7. out_valid=1 at edge k+4 with out_result=12, out_zero=0, out_overflow=0.
- Zero and overflow: stub result 0 with overflow 1 → out_result=0, out_zero=1, out_overflow=1.
- Backpressure: out_ready=0 for 10 cycles after capture. Outputs stay stable, in_ready=0, and a pending in_valid is not accepted. Raising out_ready accepts the next op on the same edge, with no gap.
- Back-to-back with out_ready=1 and SETTLE_CYCLES=1: three ops complete in 6 cycles, with results in input order.
- Async reset: pulse rst_n low mid-SETTLE (cnt=2). No out_valid is produced, and the next accepted op completes normally.

Source files
------------

// File: rtl/alu_issue_stage.sv
// -----------------------------------------------------------------------------
// alu_issue_stage
//
// Purpose:
//   Operand-issue and result-capture stage wrapped around a 32-bit
//   combinational ALU. One operation is accepted at a time over a valid/ready
//   handshake. Its operands and opcode are registered onto the ALU inputs and
//   held for SETTLE_CYCLES clocks, so the ripple chain inside the ALU can
//   resolve. The ALU result, its overflow bit and a derived zero flag are then
//   captured. They are presented to the consumer over a second valid/ready
//   handshake.
//
// Parameters:
//   SETTLE_CYCLES  clocks the operands are held before sampling (1..255)
//
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   in_valid       upstream has an operation
//   in_ready       stage can accept an operation this cycle
//   in_op/a/b      opcode and operands from upstream
//   alu_op/a/b     registered opcode/operands driven to the ALU
//   alu_result     ALU result (combinational, settles over several cycles)
//   alu_overflow   ALU overflow
//   out_valid      captured result is available
//   out_ready      consumer takes the result this cycle
//   out_result     captured result
//   out_overflow   captured overflow
//   out_zero       captured result equals zero
// -----------------------------------------------------------------------------
module alu_issue_stage #(
   parameter int unsigned SETTLE_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [2:0]  in_op,
   input  logic [31:0] in_a,
   input  logic [31:0] in_b,
   output logic [2:0]  alu_op,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   input  logic [31:0] alu_result,
   input  logic        alu_overflow,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_result,
   output logic        out_overflow,
   output logic        out_zero
);

   // Counter reload value: the SETTLE state lasts cnt+1 cycles.
   localparam logic [7:0] CNT_INIT = 8'(SETTLE_CYCLES - 32'd1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETTLE = 2'd1,
      S_HOLD   = 2'd2
   } state_t;

   // Zero detect on a captured ALU word.
   function automatic logic is_zero(input logic [31:0] value);
      return (value == 32'h0000_0000);
   endfunction

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [2:0]  op_q;
   logic [31:0] a_q, b_q;
   logic        out_valid_q, out_valid_d;
   logic [31:0] out_result_q;
   logic        out_overflow_q;
   logic        out_zero_q;

   logic        in_ready_s;
   logic        accept_s;
   logic        load_s;
   logic        capture_s;

   // Ready is gated by rst_n, so nothing is accepted while the stage is in reset.
   // HOLD with out_ready lets a new operation enter on the same edge that the
   // result leaves. This avoids a bubble cycle.
   always_comb begin
      in_ready_s = rst_n & ((state_q == S_IDLE) | ((state_q == S_HOLD) & out_ready));
      accept_s   = in_valid & in_ready_s;
   end

   // Next-state, settle counter and handshake control.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      load_s      = 1'b0;
      capture_s   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (accept_s) begin
               load_s  = 1'b1;
               cnt_d   = CNT_INIT;
               state_d = S_SETTLE;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_SETTLE: begin
            if (cnt_q != 8'd0) begin
               cnt_d = cnt_q - 8'd1;
            end else begin
               capture_s   = 1'b1;
               out_valid_d = 1'b1;
               state_d     = S_HOLD;
            end
         end
         S_HOLD: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               if (accept_s) begin
                  load_s  = 1'b1;
                  cnt_d   = CNT_INIT;
                  state_d = S_SETTLE;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               state_d = S_HOLD;
            end
         end
         default: begin
            state_d     = S_IDLE;
            cnt_d       = 8'd0;
            out_valid_d = 1'b0;
         end
      endcase
   end

   // State, counter and output-valid registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= 8'd0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
      end
   end

   // Operand registers that feed the ALU. They change only on accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q <= 3'd0;
         a_q  <= 32'h0000_0000;
         b_q  <= 32'h0000_0000;
      end else if (load_s) begin
         op_q <= in_op;
         a_q  <= in_a;
         b_q  <= in_b;
      end else begin
         op_q <= op_q;
         a_q  <= a_q;
         b_q  <= b_q;
      end
   end

   // Result registers. They change only on capture and keep their value after the handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_result_q   <= 32'h0000_0000;
         out_overflow_q <= 1'b0;
         out_zero_q     <= 1'b0;
      end else if (capture_s) begin
         out_result_q   <= alu_result;
         out_overflow_q <= alu_overflow;
         out_zero_q     <= is_zero(alu_result);
      end else begin
         out_result_q   <= out_result_q;
         out_overflow_q <= out_overflow_q;
         out_zero_q     <= out_zero_q;
      end
   end

   assign in_ready     = in_ready_s;
   assign alu_op       = op_q;
   assign alu_a        = a_q;
   assign alu_b        = b_q;
   assign out_valid    = out_valid_q;
   assign out_result   = out_result_q;
   assign out_overflow = out_overflow_q;
   assign out_zero     = out_zero_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_stage
//
// Directed bench for alu_issue_stage. u_dut4 (SETTLE_CYCLES=4) drives an adder
// stub whose output passes through a 3-stage delay line. u_dut1
// (SETTLE_CYCLES=1) drives a purely combinational adder stub. The stub
// overflow is the carry out of the 32-bit add.
// -----------------------------------------------------------------------------
module tb_alu_issue_stage;

   logic clk;
   logic rst_n;

   // u_dut4 signals
   logic        in_valid, in_ready, out_ready, out_valid, out_overflow, out_zero;
   logic [2:0]  in_op, alu_op;
   logic [31:0] in_a, in_b, alu_a, alu_b, alu_result, out_result;
   logic        alu_overflow;

   // u_dut1 signals
   logic        in_valid1, in_ready1, out_ready1, out_valid1, out_overflow1, out_zero1;
   logic [2:0]  in_op1, alu_op1;
   logic [31:0] in_a1, in_b1, alu_a1, alu_b1, alu_result1, out_result1;
   logic        alu_overflow1;

   int passed = 0;
   int total  = 0;

   alu_issue_stage #(.SETTLE_CYCLES(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_a(in_a), .in_b(in_b),
      .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
      .alu_result(alu_result), .alu_overflow(alu_overflow),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_overflow(out_overflow), .out_zero(out_zero)
   );

   alu_issue_stage #(.SETTLE_CYCLES(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid1), .in_ready(in_ready1),
      .in_op(in_op1), .in_a(in_a1), .in_b(in_b1),
      .alu_op(alu_op1), .alu_a(alu_a1), .alu_b(alu_b1),
      .alu_result(alu_result1), .alu_overflow(alu_overflow1),
      .out_valid(out_valid1), .out_ready(out_ready1),
      .out_result(out_result1), .out_overflow(out_overflow1), .out_zero(out_zero1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Slow ALU stub: a+b with carry as overflow, delayed by three clocks.
   logic [32:0] d1, d2, d3;
   initial begin
      d1 = 33'd0;
      d2 = 33'd0;
      d3 = 33'd0;
   end
   always @(posedge clk) begin
      d1 <= {1'b0, alu_a} + {1'b0, alu_b};
      d2 <= d1;
      d3 <= d2;
   end
   assign alu_result   = d3[31:0];
   assign alu_overflow = d3[32];

   // Fast ALU stub for the SETTLE_CYCLES=1 instance.
   logic [32:0] sum1;
   assign sum1          = {1'b0, alu_a1} + {1'b0, alu_b1};
   assign alu_result1   = sum1[31:0];
   assign alu_overflow1 = sum1[32];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n      = 1'b0;
      in_valid   = 1'b1;
      in_op      = 3'($urandom);
      in_a       = $urandom;
      in_b       = $urandom;
      out_ready  = 1'b1;
      in_valid1  = 1'b0;
      in_op1     = 3'd0;
      in_a1      = 32'd0;
      in_b1      = 32'd0;
      out_ready1 = 1'b0;

      // ---------------- reset ----------------
      tick();
      tick();
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_alu_a", alu_a, 32'd0);
      chk("rst_alu_b", alu_b, 32'd0);
      chk("rst_alu_op", {29'd0, alu_op}, 32'd0);
      chk("rst_out_result", out_result, 32'd0);
      chk("rst_out_flags", {30'd0, out_overflow, out_zero}, 32'd0);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      rst_n     = 1'b1;
      tick();
      chk("rel_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rel_out_valid", {31'd0, out_valid}, 32'd0);

      // ---------------- single op 5+7 ----------------
      in_valid = 1'b1;
      in_op    = 3'd3;
      in_a     = 32'd5;
      in_b     = 32'd7;
      tick();  // edge k: accept
      in_valid = 1'b0;
      in_a     = 32'hDEAD_BEEF;
      in_b     = 32'h1234_5678;
      chk("op1_alu_a", alu_a, 32'd5);
      chk("op1_alu_b", alu_b, 32'd7);
      chk("op1_alu_op", {29'd0, alu_op}, 32'd3);
      chk("op1_settle_ready", {31'd0, in_ready}, 32'd0);
      for (int i = 1; i <= 3; i++) begin
         tick();  // edges k+1 .. k+3
         chk("op1_no_valid_yet", {31'd0, out_valid}, 32'd0);
         chk("op1_alu_a_stable", alu_a, 32'd5);
      end
      tick();  // edge k+4: capture
      chk("op1_out_valid", {31'd0, out_valid}, 32'd1);
      chk("op1_result", out_result, 32'd12);
      chk("op1_zero", {31'd0, out_zero}, 32'd0);
      chk("op1_ovf", {31'd0, out_overflow}, 32'd0);

      // ---------------- backpressure with a pending op ----------------
      in_valid = 1'b1;
      in_op    = 3'd5;
      in_a     = 32'hFFFF_FFFF;
      in_b     = 32'd1;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("bp_valid", {31'd0, out_valid}, 32'd1);
         chk("bp_result", out_result, 32'd12);
         chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
         chk("bp_alu_a", alu_a, 32'd5);
      end
      out_ready = 1'b1;
      #1;
      chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
      tick();  // handshake and accept on the same edge
      in_valid  = 1'b0;
      out_ready = 1'b0;
      chk("b2b_valid_drop", {31'd0, out_valid}, 32'd0);
      chk("b2b_alu_a", alu_a, 32'hFFFF_FFFF);
      chk("b2b_alu_op", {29'd0, alu_op}, 32'd5);
      chk("b2b_result_persist", out_result, 32'd12);
      for (int i = 1; i <= 3; i++) begin
         tick();
         chk("op2_no_valid_yet", {31'd0, out_valid}, 32'd0);
      end
      tick();
      chk("op2_out_valid", {31'd0, out_valid}, 32'd1);
      chk("op2_result", out_result, 32'd0);
      chk("op2_zero", {31'd0, out_zero}, 32'd1);
      chk("op2_ovf", {31'd0, out_overflow}, 32'd1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("op2_done_valid", {31'd0, out_valid}, 32'd0);
      chk("op2_idle_ready", {31'd0, in_ready}, 32'd1);
      chk("op2_result_persist", out_result, 32'd0);

      // ---------------- async reset mid-SETTLE ----------------
      in_valid = 1'b1;
      in_a     = 32'd10;
      in_b     = 32'd20;
      tick();  // accept, counter loaded with 3
      in_valid = 1'b0;
      tick();  // counter now 2
      rst_n = 1'b0;
      #1;
      chk("arst_alu_a", alu_a, 32'd0);
      chk("arst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("arst_zero_cleared", {31'd0, out_zero}, 32'd0);
      #2;
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("arst_no_emit", {31'd0, out_valid}, 32'd0);
      end
      in_valid = 1'b1;
      in_op    = 3'd1;
      in_a     = 32'd100;
      in_b     = 32'd23;
      tick();
      in_valid = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         tick();
         chk("arst_op_wait", {31'd0, out_valid}, 32'd0);
      end
      tick();
      chk("arst_op_valid", {31'd0, out_valid}, 32'd1);
      chk("arst_op_result", out_result, 32'd123);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("arst_op_done", {31'd0, out_valid}, 32'd0);

      // ---------------- SETTLE_CYCLES=1 back-to-back ----------------
      out_ready1 = 1'b1;
      in_valid1  = 1'b1;
      in_a1      = 32'd1;
      in_b1      = 32'd1;
      tick();  // e1: accept op A
      in_a1 = 32'd2;
      in_b1 = 32'd2;
      chk("s1_settle_ready", {31'd0, in_ready1}, 32'd0);
      tick();  // e2: capture A
      chk("s1_a_valid", {31'd0, out_valid1}, 32'd1);
      chk("s1_a_result", out_result1, 32'd2);
      chk("s1_hold_ready", {31'd0, in_ready1}, 32'd1);
      tick();  // e3: hand A off, accept B
      in_a1 = 32'd3;
      in_b1 = 32'd3;
      chk("s1_gap_valid", {31'd0, out_valid1}, 32'd0);
      chk("s1_b_alu_a", alu_a1, 32'd2);
      tick();  // e4: capture B
      chk("s1_b_valid", {31'd0, out_valid1}, 32'd1);
      chk("s1_b_result", out_result1, 32'd4);
      tick();  // e5: hand B off, accept C
      in_valid1 = 1'b0;
      tick();  // e6: capture C
      chk("s1_c_valid", {31'd0, out_valid1}, 32'd1);
      chk("s1_c_result", out_result1, 32'd6);
      tick();  // e7: hand C off, back to idle
      chk("s1_end_valid", {31'd0, out_valid1}, 32'd0);
      chk("s1_end_ready", {31'd0, in_ready1}, 32'd1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
